// File: rtl/add_sub_cmd_master.sv
// add_sub_cmd_master
// Queues add/subtract commands in a small FIFO, drives an external add_sub
// unit one command at a time, captures its result, checks it against the
// locally computed expected value and returns it on a valid/ready response
// channel tagged with a 4-bit sequence number.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   cmd_valid/ready    : command handshake; cmd_op (1 = add, 0 = sub),
//                        cmd_a, cmd_b operands
//   as_en_out          : one-cycle enable pulse to add_sub
//   as_control_out     : add_sub control (op of the command in flight)
//   as_data1/2_out     : add_sub operands, held until the next pop
//   as_y_in            : add_sub result (DATA_WIDTH+1 bits)
//   rsp_valid/ready    : response handshake; rsp_result, rsp_op, rsp_seq,
//                        rsp_err (result differs from expected)
//   busy               : FIFO non-empty or command in flight
module add_sub_cmd_master #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   output logic                  as_en_out,
   output logic                  as_control_out,
   output logic [DATA_WIDTH-1:0] as_data1_out,
   output logic [DATA_WIDTH-1:0] as_data2_out,
   input  logic [DATA_WIDTH:0]   as_y_in,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH:0]   rsp_result,
   output logic                  rsp_op,
   output logic [3:0]            rsp_seq,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned RW = DATA_WIDTH + 1;

   typedef struct packed {
      logic                  op;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            pop;
   logic            push;
   logic            full;
   logic            empty;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   entry_t          mem [FIFO_DEPTH];
   entry_t          head;
   logic [3:0]      seq_cnt;
   logic [3:0]      cur_seq;
   logic [RW-1:0]   exp_y;

   // FIFO status; count register makes full/empty exact for any depth
   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem[rd_ptr];
   assign busy      = !empty || (state != IDLE);

   // Reference result: zero-extended operands, modulo 2^(DATA_WIDTH+1)
   assign exp_y = as_control_out ? (RW'(as_data1_out) + RW'(as_data2_out))
                                 : (RW'(as_data1_out) - RW'(as_data2_out));

   // Next-state and pop decision
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT:  state_next = RESP;
         RESP: begin
            // rsp_valid is high for the whole of RESP, so rsp_ready is the handshake
            if (rsp_ready) begin
               if (!empty) begin
                  pop        = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         as_en_out      <= 1'b0;
         as_control_out <= 1'b0;
         as_data1_out   <= '0;
         as_data2_out   <= '0;
         rsp_valid      <= 1'b0;
         rsp_result     <= '0;
         rsp_op         <= 1'b0;
         rsp_seq        <= '0;
         rsp_err        <= 1'b0;
         seq_cnt        <= '0;
         cur_seq        <= '0;
      end else begin
         state     <= state_next;
         as_en_out <= (state_next == ISSUE);
         rsp_valid <= (state_next == RESP);
         if (pop) begin
            as_control_out <= head.op;
            as_data1_out   <= head.a;
            as_data2_out   <= head.b;
            cur_seq        <= seq_cnt;
            seq_cnt        <= seq_cnt + 4'd1;
         end
         // add_sub result is valid during WAIT
         if (state == WAIT) begin
            rsp_result <= as_y_in;
            rsp_err    <= (as_y_in != exp_y);
            rsp_op     <= as_control_out;
            rsp_seq    <= cur_seq;
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; data needs no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
      end
   end

endmodule

// File: tb/tb_add_sub_cmd_master.sv
module tb_add_sub_cmd_master;

   localparam int unsigned DW    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned RW    = DW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_op;
   logic [DW-1:0] cmd_a;
   logic [DW-1:0] cmd_b;
   logic          as_en_out;
   logic          as_control_out;
   logic [DW-1:0] as_data1_out;
   logic [DW-1:0] as_data2_out;
   logic [RW-1:0] as_y_in;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [RW-1:0] rsp_result;
   logic          rsp_op;
   logic [3:0]    rsp_seq;
   logic          rsp_err;
   logic          busy;

   add_sub_cmd_master #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .as_en_out(as_en_out), .as_control_out(as_control_out),
      .as_data1_out(as_data1_out), .as_data2_out(as_data2_out),
      .as_y_in(as_y_in),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_op(rsp_op), .rsp_seq(rsp_seq), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // External add_sub unit: registered result on en; fault makes it compute b-a
   bit            fault = 1'b0;
   logic [RW-1:0] y_reg;
   assign as_y_in = y_reg;
   always_ff @(posedge clk) begin
      if (rst) y_reg <= '0;
      else if (as_en_out) begin
         if (fault) y_reg <= RW'(as_data2_out) - RW'(as_data1_out);
         else if (as_control_out) y_reg <= RW'(as_data1_out) + RW'(as_data2_out);
         else y_reg <= RW'(as_data1_out) - RW'(as_data2_out);
      end
   end

   typedef struct {
      int op;
      int a;
      int b;
   } cmd_t;

   cmd_t  model_q[$];
   int    tests = 0;
   int    fails = 0;
   int    exp_seq = 0;
   int    cyc = 0;
   int    n_rsp = 0;
   int    last_rsp_cyc = -1;
   int    seq17 = -1;
   bit    spacing_chk = 1'b0;
   bit    last_acc = 1'b0;
   bit    prev_stall = 1'b0;
   logic [RW-1:0] hold_res;
   logic          hold_op;
   logic [3:0]    hold_seq;
   logic          hold_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Response scoreboard: expected values from plain modular arithmetic
   task automatic check_rsp();
      cmd_t c;
      int   m, good, bad, exp_y, exp_err;
      if (model_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL rsp_unexpected: observed response seq %0d expected none", rsp_seq);
         return;
      end
      c       = model_q.pop_front();
      m       = 1 << RW;
      good    = (c.op != 0) ? (c.a + c.b) % m : (c.a - c.b + m) % m;
      bad     = (c.b - c.a + m) % m;
      exp_y   = fault ? bad : good;
      exp_err = (fault && bad != good) ? 1 : 0;
      check("rsp_result", 32'(rsp_result), exp_y);
      check("rsp_op", 32'(rsp_op), c.op);
      check("rsp_seq", 32'(rsp_seq), exp_seq);
      check("rsp_err", 32'(rsp_err), exp_err);
      if (n_rsp == 16) seq17 = int'(rsp_seq);
      exp_seq = (exp_seq + 1) % 16;
      if (spacing_chk && last_rsp_cyc >= 0) check("rsp_spacing", cyc - last_rsp_cyc, 3);
      last_rsp_cyc = cyc;
      n_rsp++;
   endtask

   // One clock: observe handshakes at negedge, return 1 time unit after posedge
   task automatic step();
      @(negedge clk);
      cyc++;
      last_acc = 1'b0;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
         model_q.push_back('{int'(cmd_op), int'(cmd_a), int'(cmd_b)});
         last_acc = 1'b1;
      end
      if (rsp_valid === 1'b1 && prev_stall) begin
         check("hold_result", 32'(rsp_result), 32'(hold_res));
         check("hold_op", 32'(rsp_op), 32'(hold_op));
         check("hold_seq", 32'(rsp_seq), 32'(hold_seq));
         check("hold_err", 32'(rsp_err), 32'(hold_err));
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) check_rsp();
      prev_stall = (rsp_valid === 1'b1 && rsp_ready !== 1'b1);
      hold_res = rsp_result;
      hold_op  = rsp_op;
      hold_seq = rsp_seq;
      hold_err = rsp_err;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      model_q.delete();
      exp_seq      = 0;
      prev_stall   = 1'b0;
      last_rsp_cyc = -1;
      n_rsp        = 0;
   endtask

   task automatic offer(input int op, input int a, input int b, input int bound, output bit acc);
      cmd_valid = 1'b1;
      cmd_op    = op[0];
      cmd_a     = a[DW-1:0];
      cmd_b     = b[DW-1:0];
      acc       = 1'b0;
      for (int i = 0; i < bound && !acc; i++) begin
         step();
         acc = last_acc;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int bound);
      for (int i = 0; i < bound && rsp_valid !== 1'b1; i++) step();
      check(tag, 32'(rsp_valid), 1);
   endtask

   task automatic drain(input int bound);
      rsp_ready = 1'b1;
      for (int i = 0; i < bound && model_q.size() != 0; i++) step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      bit acc;
      int acc_cnt, base, sent;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      step();
      step();
      // Reset values while rst is still asserted
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_as_en", 32'(as_en_out), 0);
      check("rst_as_ctrl", 32'(as_control_out), 0);
      check("rst_as_d1", 32'(as_data1_out), 0);
      check("rst_as_d2", 32'(as_data2_out), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_result", 32'(rsp_result), 0);
      check("rst_rsp_op", 32'(rsp_op), 0);
      check("rst_rsp_seq", 32'(rsp_seq), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(cmd_ready), 1);

      // Single add 7+9 with latency checks
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 4'd7; cmd_b = 4'd9;
      step();
      check("add_accepted", 32'(last_acc), 1);
      cmd_valid = 1'b0;
      check("add_en_n", 32'(as_en_out), 0);
      step();
      check("add_en_n1", 32'(as_en_out), 1);
      check("add_rv_n1", 32'(rsp_valid), 0);
      step();
      check("add_en_n2", 32'(as_en_out), 0);
      check("add_rv_n2", 32'(rsp_valid), 0);
      step();
      check("add_rv_n3", 32'(rsp_valid), 1);
      check("add_result", 32'(rsp_result), 16);
      check("add_seq", 32'(rsp_seq), 0);
      check("add_err", 32'(rsp_err), 0);
      check("add_d1_held", 32'(as_data1_out), 7);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("add_rv_done", 32'(rsp_valid), 0);
      check("add_busy_done", 32'(busy), 0);

      // Subtract wrap 3-5, then same with a faulty add_sub
      offer(0, 3, 5, 8, acc);
      wait_rsp("sub_valid", 10);
      check("sub_result", 32'(rsp_result), 30);
      check("sub_err", 32'(rsp_err), 0);
      drain(10);
      fault = 1'b1;
      offer(0, 3, 5, 8, acc);
      wait_rsp("fault_valid", 10);
      check("fault_result", 32'(rsp_result), 2);
      check("fault_err", 32'(rsp_err), 1);
      drain(10);
      fault = 1'b0;

      // Backpressure: one command in flight plus a full FIFO
      do_reset();
      acc_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         offer(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 8, acc);
         if (acc) acc_cnt++;
      end
      check("bp_accepted", acc_cnt, DEPTH + 1);
      check("bp_cmd_ready", 32'(cmd_ready), 0);
      check("bp_busy", 32'(busy), 1);
      base = n_rsp;
      drain(40);
      check("bp_responses", n_rsp - base, DEPTH + 1);
      step();
      step();
      check("bp_rv_idle", 32'(rsp_valid), 0);
      check("bp_busy_idle", 32'(busy), 0);

      // Streaming 20 commands with rsp_ready high
      do_reset();
      spacing_chk = 1'b1;
      rsp_ready   = 1'b1;
      sent        = 0;
      base        = n_rsp;
      cmd_valid   = 1'b1;
      cmd_op = 1'($urandom_range(0, 1)); cmd_a = DW'($urandom); cmd_b = DW'($urandom);
      for (int i = 0; i < 300 && (n_rsp - base) < 20; i++) begin
         step();
         if (last_acc) begin
            sent++;
            if (sent < 20) begin
               cmd_op = 1'($urandom_range(0, 1)); cmd_a = DW'($urandom); cmd_b = DW'($urandom);
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid   = 1'b0;
      rsp_ready   = 1'b0;
      spacing_chk = 1'b0;
      check("stream_count", n_rsp - base, 20);
      check("stream_seq_wrap", seq17, 0);

      // Reset while WAIT with two entries queued
      do_reset();
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 4'd1; cmd_b = 4'd2;
      step();
      cmd_a = 4'd3;
      step();
      cmd_a = 4'd5;
      step();
      cmd_valid = 1'b0;
      check("wait_busy", 32'(busy), 1);
      rst = 1'b1;
      step();
      check("rstwait_rv", 32'(rsp_valid), 0);
      check("rstwait_busy", 32'(busy), 0);
      check("rstwait_en", 32'(as_en_out), 0);
      rst = 1'b0;
      #1;
      check("rstwait_ready", 32'(cmd_ready), 1);
      model_q.delete();
      exp_seq = 0;
      offer(1, 4, 4, 8, acc);
      wait_rsp("rstwait_valid", 10);
      check("rstwait_seq", 32'(rsp_seq), 0);
      check("rstwait_result", 32'(rsp_result), 8);
      drain(10);

      // Random traffic with random response backpressure
      sent = 0;
      for (int i = 0; i < 800; i++) begin
         if (sent >= 30 && model_q.size() == 0 && rsp_valid !== 1'b1) break;
         if (!cmd_valid && sent < 30 && $urandom_range(0, 1) == 1) begin
            cmd_valid = 1'b1;
            cmd_op = 1'($urandom_range(0, 1)); cmd_a = DW'($urandom); cmd_b = DW'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
         if (last_acc) begin
            cmd_valid = 1'b0;
            sent++;
         end
      end
      rsp_ready = 1'b0;
      check("rand_sent", sent, 30);
      check("rand_drained", model_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
